// File: rtl/dct_block_arbiter_if.sv
// dct_block_arbiter_if: requester-side and DCT-side stream signals of the
// block arbiter, bundled so the arbiter and its environment share one port.
//
// Handshake: on every stream a beat transfers on a rising clock edge where
// tvalid and tready are both 1. A source that raises tvalid keeps tvalid,
// tdata, tlast and tuser stable until that transfer happens. A sink may
// drive tready independently of tvalid.
interface dct_block_arbiter_if #(
  parameter int N_REQ       = 3,
  parameter int TDATA_WIDTH = 64,
  parameter int ID_W        = $clog2(N_REQ)
);
  logic [N_REQ-1:0]             s_tvalid_i;
  logic [N_REQ-1:0]             s_tready_o;
  logic [N_REQ*TDATA_WIDTH-1:0] s_tdata_i;
  logic [N_REQ-1:0]             s_tlast_i;
  logic [N_REQ-1:0]             s_tuser_i;
  logic                         m_tvalid_o;
  logic                         m_tready_i;
  logic [TDATA_WIDTH-1:0]       m_tdata_o;
  logic                         m_tlast_o;
  logic                         m_tuser_o;
  logic [ID_W-1:0]              m_tid_o;

  // Arbiter side: consumes the requester streams, produces the tagged stream.
  modport master (
    input  s_tvalid_i, s_tdata_i, s_tlast_i, s_tuser_i, m_tready_i,
    output s_tready_o, m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o, m_tid_o
  );

  // Environment side: requesters and the DCT engine.
  modport slave (
    output s_tvalid_i, s_tdata_i, s_tlast_i, s_tuser_i, m_tready_i,
    input  s_tready_o, m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o, m_tid_o
  );
endinterface

// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter: shares one 8x8 DCT engine between N_REQ row streams.
// Whole blocks of BEATS_PER_BLOCK beats are granted in round-robin order and
// never interrupted; each output beat carries the granted requester index.
// Optional feature macro DCT_ARB_420_EN: requester 0 (luma) keeps the grant
// for up to 4 consecutive blocks, giving 4:2:0 MCU order Y Y Y Y Cb Cr.
module dct_block_arbiter #(
  parameter int N_REQ           = 3,
  parameter int PX_WIDTH        = 8,
  parameter int TDATA_WIDTH     = PX_WIDTH*8,
  parameter int BEATS_PER_BLOCK = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  dct_block_arbiter_if.master bus,
  output logic                blk_done_o,
  output logic                err_o,
  output logic                dbg_state_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BEATS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_BLOCK-1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ-1);
  localparam logic [ID_W:0]    N_REQ_EXT = (ID_W+1)'(N_REQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]    pick;
  logic               pick_vld;
  logic [ID_W-1:0]    grant_next;

  logic               sel_valid;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic               sel_last;
  logic               sel_user;
  logic               in_ready;
  logic               in_acc;
  logic               last_acc;
  logic               frame_err;
  logic [N_REQ-1:0]   s_tready;

  logic               m_tvalid_q;
  logic [TDATA_WIDTH-1:0] m_tdata_q;
  logic               m_tlast_q;
  logic               m_tuser_q;
  logic [ID_W-1:0]    m_tid_q;
  logic               blk_done_q;
  logic               err_q;

`ifdef DCT_ARB_420_EN
  logic [1:0]         luma_cnt_q, luma_cnt_d;
`endif

  // Granted requester's beat; only meaningful while LOCKed.
  assign sel_valid = bus.s_tvalid_i[grant_q];
  assign sel_data  = bus.s_tdata_i[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
  assign sel_last  = bus.s_tlast_i[grant_q];
  assign sel_user  = bus.s_tuser_i[grant_q];

  // The output register can take a new beat when empty or draining this cycle.
  assign in_ready   = (state_q == LOCK) && (!m_tvalid_q || bus.m_tready_i);
  assign in_acc     = in_ready && sel_valid;
  assign last_acc   = in_acc && (beat_cnt_q == LAST_BEAT);
  assign grant_next = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  // tuser only belongs on the first row of a block, tlast only on the last.
  assign frame_err = in_acc &&
                     ((sel_user && (beat_cnt_q != '0)) ||
                      (sel_last && (beat_cnt_q != LAST_BEAT)));

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0] cand;
    cand     = '0;
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= N_REQ_EXT) cand = cand - N_REQ_EXT;
      if (!pick_vld && bus.s_tvalid_i[cand[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[ID_W-1:0];
      end
    end
  end

  // Only the granted requester sees ready, and only while LOCKed.
  always_comb begin
    s_tready          = '0;
    s_tready[grant_q] = in_ready;
  end

  // Next-state logic: IDLE arbitrates for one cycle, LOCK streams one block.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
`ifdef DCT_ARB_420_EN
    luma_cnt_d = luma_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef DCT_ARB_420_EN
        // Luma has nothing to send at its turn: its burst is over.
        if ((rr_ptr_q == '0) && !bus.s_tvalid_i[0]) luma_cnt_d = '0;
`endif
        if (pick_vld) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (in_acc) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
            rr_ptr_d   = grant_next;
`ifdef DCT_ARB_420_EN
            // Luma keeps the pointer until its fourth consecutive block.
            if ((grant_q == '0) && (luma_cnt_q != 2'd3)) begin
              rr_ptr_d   = '0;
              luma_cnt_d = luma_cnt_q + 2'd1;
            end else begin
              luma_cnt_d = '0;
            end
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DCT_ARB_420_EN
  // Consecutive luma block counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) luma_cnt_q <= '0;
    else          luma_cnt_q <= luma_cnt_d;
  end
`endif

  // Output register: loads on input accept, empties when the engine takes it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tid_q    <= '0;
    end else if (in_acc) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= sel_data;
      m_tlast_q  <= sel_last;
      m_tuser_q  <= sel_user;
      m_tid_q    <= grant_q;
    end else if (bus.m_tready_i) begin
      m_tvalid_q <= 1'b0;
    end
  end

  // Block-done pulse and sticky framing error.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      blk_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      blk_done_q <= last_acc;
      if (frame_err) err_q <= 1'b1;
    end
  end

  assign bus.s_tready_o = s_tready;
  assign bus.m_tvalid_o = m_tvalid_q;
  assign bus.m_tdata_o  = m_tdata_q;
  assign bus.m_tlast_o  = m_tlast_q;
  assign bus.m_tuser_o  = m_tuser_q;
  assign bus.m_tid_o    = m_tid_q;
  assign blk_done_o     = blk_done_q;
  assign err_o          = err_q;
  assign dbg_state_o    = (state_q == LOCK);

endmodule

// File: tb/tb_dct_block_arbiter.sv
// tb_dct_block_arbiter: randomized requester streams against a
// transaction-level model of the block arbiter, plus directed scenarios.
module tb_dct_block_arbiter;
  localparam int N_REQ       = 3;
  localparam int PX_WIDTH    = 8;
  localparam int TDATA_WIDTH = 64;
  localparam int BPB         = 8;
  localparam int ID_W        = $clog2(N_REQ);
  localparam int BEAT_W      = ID_W + 2 + TDATA_WIDTH;
  localparam logic [TDATA_WIDTH-1:0] ROW_BASE = 64'h0706050403020100;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic blk_done;
  logic err;
  logic dbg_state;
  always #5 clk = ~clk;

  dct_block_arbiter_if #(.N_REQ(N_REQ), .TDATA_WIDTH(TDATA_WIDTH)) bus ();

  dct_block_arbiter #(
    .N_REQ(N_REQ), .PX_WIDTH(PX_WIDTH), .TDATA_WIDTH(TDATA_WIDTH),
    .BEATS_PER_BLOCK(BPB)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
    .blk_done_o(blk_done), .err_o(err), .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit rst_req  = 1'b1;

  // stimulus knobs
  int p_valid[N_REQ];
  int inj_last[N_REQ];
  int ready_mode   = 0;
  bit pattern      = 1'b0;
  int inj_user_pct = 0;
  int bidx[N_REQ];
  logic [N_REQ-1:0] acc_prev = '0;

  // reference model (block-level rules)
  bit md_locked = 1'b0;
  int md_grant  = 0;
  int md_ptr    = 0;
  int md_cnt    = 0;
  bit md_ovalid = 1'b0;
  bit md_err    = 1'b0;
  bit md_done   = 1'b0;
`ifdef DCT_ARB_420_EN
  int md_luma   = 0;
`endif
  logic [BEAT_W-1:0] exp_q[$];

  // observations
  int blk_tids[$];
  int done_cycles[$];
  logic [TDATA_WIDTH-1:0] out_data[$];
  int out_n = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] exp_ready();
    logic [N_REQ-1:0] r;
    r = '0;
    if (md_locked) r[md_grant] = !md_ovalid || bus.m_tready_i;
    return r;
  endfunction

  // One clock of the model, using the inputs that the next edge will see.
  task automatic model_step();
    logic [N_REQ-1:0] rdy;
    bit acc;
    bit found;
    if (!rst_n) begin
      md_locked = 0; md_grant = 0; md_ptr = 0; md_cnt = 0;
      md_ovalid = 0; md_err = 0; md_done = 0;
`ifdef DCT_ARB_420_EN
      md_luma = 0;
`endif
      exp_q.delete();
      return;
    end
    rdy     = exp_ready();
    acc     = md_locked && bus.s_tvalid_i[md_grant] && rdy[md_grant];
    md_done = 0;
    if (!md_locked) begin
`ifdef DCT_ARB_420_EN
      if (md_ptr == 0 && !bus.s_tvalid_i[0]) md_luma = 0;
`endif
      found = 0;
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (md_ptr + k) % N_REQ;
        if (!found && bus.s_tvalid_i[idx]) begin
          found = 1; md_grant = idx; md_locked = 1;
        end
      end
    end else if (acc) begin
      exp_q.push_back({ID_W'(md_grant), bus.s_tuser_i[md_grant], bus.s_tlast_i[md_grant],
                       bus.s_tdata_i[md_grant*TDATA_WIDTH +: TDATA_WIDTH]});
      if ((bus.s_tuser_i[md_grant] && md_cnt != 0) ||
          (bus.s_tlast_i[md_grant] && md_cnt != BPB-1)) md_err = 1;
      if (md_cnt == BPB-1) begin
        md_cnt = 0; md_locked = 0; md_done = 1;
        md_ptr = (md_grant + 1) % N_REQ;
`ifdef DCT_ARB_420_EN
        if (md_grant == 0 && md_luma != 3) begin md_ptr = 0; md_luma++; end
        else md_luma = 0;
`endif
      end else begin
        md_cnt++;
      end
    end
    if (acc) md_ovalid = 1;
    else if (bus.m_tready_i) md_ovalid = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    case (ready_mode)
      0:       bus.m_tready_i = 1'b1;
      1:       bus.m_tready_i = ($urandom_range(99) < 70);
      default: bus.m_tready_i = (cyc % 2 == 0);
    endcase
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst_n) begin
        bus.s_tvalid_i[i] = 1'b0;
        bidx[i] = 0;
        continue;
      end
      if (acc_prev[i]) bidx[i] = (bidx[i] + 1) % BPB;
      else if (bus.s_tvalid_i[i]) continue;
      if ($urandom_range(99) < p_valid[i]) begin
        bus.s_tvalid_i[i] = 1'b1;
        bus.s_tdata_i[i*TDATA_WIDTH +: TDATA_WIDTH] =
          pattern ? ROW_BASE + TDATA_WIDTH'(bidx[i]) : {$urandom, $urandom};
        bus.s_tlast_i[i] = (bidx[i] == BPB-1) || (bidx[i] == inj_last[i]);
        bus.s_tuser_i[i] = (bidx[i] == 0) ? ($urandom_range(3) == 0)
                                          : ($urandom_range(99) < inj_user_pct);
      end else begin
        bus.s_tvalid_i[i] = 1'b0;
      end
    end
  endtask

  task automatic pop_output();
    logic [BEAT_W-1:0] got;
    got = {bus.m_tid_o, bus.m_tuser_o, bus.m_tlast_o, bus.m_tdata_o};
    check("exp_q_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) check("out_beat", got, exp_q.pop_front());
    if (out_n % BPB == 0) blk_tids.push_back(int'(bus.m_tid_o));
    out_data.push_back(bus.m_tdata_o);
    out_n++;
  endtask

  // One clock: check registered outputs, drive, check ready, step model.
  task automatic cycle();
    logic [N_REQ-1:0] rdy;
    @(negedge clk);
    check("m_tvalid", bus.m_tvalid_o, md_ovalid);
    check("err_o", err, md_err);
    check("blk_done", blk_done, md_done);
    if (blk_done) done_cycles.push_back(cyc);
    rst_n = !rst_req;
    drive_inputs();
    #1;
    rdy = bus.s_tready_o;
    check("s_tready", rdy, exp_ready());
    if (rst_n) begin
      if (bus.m_tvalid_o && bus.m_tready_i) pop_output();
      acc_prev = bus.s_tvalid_i & rdy;
    end else begin
      acc_prev = '0;
    end
    model_step();
    cyc++;
  endtask

  task automatic clear_obs();
    blk_tids.delete();
    done_cycles.delete();
    out_data.delete();
    out_n = 0;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
    clear_obs();
  endtask

  // ---------------- scenarios ----------------
  int exp_seq[12];
  initial begin
    bus.s_tvalid_i = '0; bus.s_tdata_i = '0; bus.s_tlast_i = '0;
    bus.s_tuser_i  = '0; bus.m_tready_i = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      p_valid[i] = 0; inj_last[i] = -1; bidx[i] = 0;
    end

    // reset state
    do_reset();
    check("rst_m_tdata", bus.m_tdata_o, 0);
    check("rst_m_tid", bus.m_tid_o, 0);
    check("rst_m_tlast", bus.m_tlast_o, 0);
    check("rst_m_tuser", bus.m_tuser_o, 0);
    check("rst_state", dbg_state, 0);

    // all requesters continuously valid, engine always ready
`ifdef DCT_ARB_420_EN
    exp_seq = '{0,0,0,0,1,2,0,0,0,0,1,2};
`else
    exp_seq = '{0,1,2,0,1,2,0,1,2,0,1,2};
`endif
    p_valid = '{100,100,100};
    repeat (12*9 + 6) cycle();
    check("t1_block_count", blk_tids.size() >= 12, 1'b1);
    for (int k = 0; k < 12 && k < blk_tids.size(); k++)
      check($sformatf("t1_tid%0d", k), blk_tids[k], exp_seq[k]);
    check("t1_done_count", done_cycles.size() >= 3, 1'b1);
    if (done_cycles.size() >= 3) begin
      check("t1_done_gap", done_cycles[1] - done_cycles[0], 9);
      check("t1_three_blocks", done_cycles[2] - done_cycles[0], 18);
    end

    // only requester 2 valid
    do_reset();
    p_valid = '{0,0,100};
    repeat (60) cycle();
    check("t2_block_count", blk_tids.size() >= 5, 1'b1);
    foreach (blk_tids[k]) check("t2_tid", blk_tids[k], 2);
    for (int k = 1; k < done_cycles.size(); k++)
      check("t2_done_gap", done_cycles[k] - done_cycles[k-1], 9);

    // engine ready toggling during a block
    do_reset();
    p_valid = '{100,0,0}; pattern = 1'b1; ready_mode = 2;
    for (int c = 0; c < 80 && out_n < 8; c++) cycle();
    check("t3_rows_out", out_n >= 8, 1'b1);
    for (int k = 0; k < 8 && k < out_data.size(); k++)
      check($sformatf("t3_row%0d", k), out_data[k], ROW_BASE + TDATA_WIDTH'(k));
    pattern = 1'b0; ready_mode = 0;

    // requester 1 raises tlast on beat 5
    do_reset();
    p_valid = '{0,100,0}; inj_last[1] = 5;
    repeat (30) cycle();
    check("t4_err_sticky", err, 1'b1);
    check("t4_block_done", done_cycles.size() >= 2, 1'b1);
    inj_last[1] = -1;

    // reset in the middle of requester 1's block
    do_reset();
    p_valid = '{100,100,100};
    for (int c = 0; c < 100 && out_n < 11; c++) cycle();
    check("t5_progress", out_n >= 11, 1'b1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    @(posedge clk);
    #1;
    check("t5_m_tvalid", bus.m_tvalid_o, 1'b0);
    check("t5_err", err, 1'b0);
    check("t5_s_tready", bus.s_tready_o, '0);
    clear_obs();
    repeat (30) cycle();
    check("t5_next_grant", blk_tids.size() > 0 ? blk_tids[0] : -1, 0);

    // randomized traffic, random engine backpressure, occasional bad tuser
    do_reset();
    ready_mode = 1; inj_user_pct = 3;
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < N_REQ; i++) p_valid[i] = $urandom_range(100, 20);
      repeat (200) cycle();
    end
    check("rand_blocks", done_cycles.size() > 0, 1'b1);
    p_valid = '{0,0,0}; ready_mode = 0; inj_user_pct = 0;
    repeat (30) cycle();
    check("rand_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
